// File: rtl/id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_hazard_reg
//  Purpose  : ID/EX pipeline register for the 5-stage 64-bit LEGv8 pipeline
//             with integrated load-use hazard detection. A load in EX whose
//             destination feeds the instruction in ID stalls PC and IF/ID
//             for one cycle and a bubble is loaded into EX. A taken branch
//             (flush) squashes the ID instruction and overrides the stall.
//  Ports    : clk, reset_n          - rising-edge clock, async active-low reset
//             id_*                  - decoded instruction from ID
//             flush                 - taken branch resolved, squash ID
//             stall_o               - hold PC and IF/ID this cycle
//             ex_*                  - registered instruction presented to EX
//                                     and to the forwarding unit
//             stall_count           - load-use bubbles inserted, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_hazard_reg #(
  parameter int DATA_WIDTH = 64,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_alu_src,
  input  logic [2:0]            id_alu_op,
  input  logic                  id_set_flags,
  input  logic                  id_uses_rm,
  input  logic [REG_W-1:0]      id_rn,
  input  logic [REG_W-1:0]      id_rm,
  input  logic [REG_W-1:0]      id_rd,
  input  logic [DATA_WIDTH-1:0] id_rdata1,
  input  logic [DATA_WIDTH-1:0] id_rdata2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic                  flush,
  output logic                  stall_o,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic                  ex_set_flags,
  output logic [2:0]            ex_alu_op,
  output logic [REG_W-1:0]      ex_rn,
  output logic [REG_W-1:0]      ex_rm,
  output logic [REG_W-1:0]      ex_rd,
  output logic [DATA_WIDTH-1:0] ex_rdata1,
  output logic [DATA_WIDTH-1:0] ex_rdata2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [CNT_W-1:0]      stall_count
);

  // X31 reads as zero, so a load targeting it produces nothing to wait for.
  localparam logic [REG_W-1:0] c_XZR     = {REG_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  // Registered EX state
  logic                  valid_q,     valid_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_read_q,  mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  alu_src_q,   alu_src_d;
  logic                  set_flags_q, set_flags_d;
  logic [2:0]            alu_op_q,    alu_op_d;
  logic [REG_W-1:0]      rn_q,        rn_d;
  logic [REG_W-1:0]      rm_q,        rm_d;
  logic [REG_W-1:0]      rd_q,        rd_d;
  logic [DATA_WIDTH-1:0] rdata1_q,    rdata1_d;
  logic [DATA_WIDTH-1:0] rdata2_q,    rdata2_d;
  logic [DATA_WIDTH-1:0] imm_q,       imm_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;

  logic w_rd_match;
  logic w_hazard;

  // Rm only counts as a source when the ID instruction actually reads it;
  // I-type encodings leave garbage in that field.
  assign w_rd_match = (rd_q == id_rn) | (id_uses_rm & (rd_q == id_rm));
  assign w_hazard   = id_valid & valid_q & mem_read_q & (rd_q != c_XZR) & w_rd_match;
  // A taken branch discards the ID instruction, so there is nothing to hold.
  assign stall_o    = w_hazard & ~flush;

  always_comb begin
    // Default: bubble (no control, XZR specifiers, zero data)
    valid_d      = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_src_d    = 1'b0;
    set_flags_d  = 1'b0;
    alu_op_d     = 3'b000;
    rn_d         = c_XZR;
    rm_d         = c_XZR;
    rd_d         = c_XZR;
    rdata1_d     = '0;
    rdata2_d     = '0;
    imm_d        = '0;
    cnt_d        = cnt_q;

    if (flush) begin
      // bubble, counter untouched
    end else if (w_hazard) begin
      if (cnt_q != c_CNT_MAX) begin
        cnt_d = cnt_q + c_CNT_ONE;
      end
    end else begin
      // Fields always follow ID; control is gated so an invalid slot
      // can never write registers, memory or flags.
      valid_d      = id_valid;
      reg_write_d  = id_reg_write  & id_valid;
      mem_read_d   = id_mem_read   & id_valid;
      mem_write_d  = id_mem_write  & id_valid;
      mem_to_reg_d = id_mem_to_reg & id_valid;
      alu_src_d    = id_alu_src    & id_valid;
      set_flags_d  = id_set_flags  & id_valid;
      alu_op_d     = id_alu_op & {3{id_valid}};
      rn_d         = id_rn;
      rm_d         = id_rm;
      rd_d         = id_rd;
      rdata1_d     = id_rdata1;
      rdata2_d     = id_rdata2;
      imm_d        = id_imm;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      set_flags_q  <= 1'b0;
      alu_op_q     <= 3'b000;
      rn_q         <= c_XZR;
      rm_q         <= c_XZR;
      rd_q         <= c_XZR;
      rdata1_q     <= '0;
      rdata2_q     <= '0;
      imm_q        <= '0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_src_q    <= alu_src_d;
      set_flags_q  <= set_flags_d;
      alu_op_q     <= alu_op_d;
      rn_q         <= rn_d;
      rm_q         <= rm_d;
      rd_q         <= rd_d;
      rdata1_q     <= rdata1_d;
      rdata2_q     <= rdata2_d;
      imm_q        <= imm_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_set_flags  = set_flags_q;
  assign ex_alu_op     = alu_op_q;
  assign ex_rn         = rn_q;
  assign ex_rm         = rm_q;
  assign ex_rd         = rd_q;
  assign ex_rdata1     = rdata1_q;
  assign ex_rdata2     = rdata2_q;
  assign ex_imm        = imm_q;
  assign stall_count   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_hazard_reg
//  Purpose  : Self-checking bench for id_ex_hazard_reg. Directed scenarios
//             followed by random traffic, compared against a transaction-
//             level model of the EX slot. A second instance built with a
//             2-bit stall counter shares all stimulus to exercise saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_hazard_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        id_alu_src, id_set_flags, id_uses_rm, flush;
  logic [2:0]  id_alu_op;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic [63:0] id_rdata1, id_rdata2, id_imm;

  logic        stall_o, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_alu_src, ex_set_flags;
  logic [2:0]  ex_alu_op;
  logic [4:0]  ex_rn, ex_rm, ex_rd;
  logic [63:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [15:0] stall_count;

  logic        s_stall, s_valid, s_rw, s_mr, s_mw, s_m2r, s_as, s_sf;
  logic [2:0]  s_op;
  logic [4:0]  s_rn, s_rm, s_rd;
  logic [63:0] s_d1, s_d2, s_imm;
  logic [1:0]  s_count;

  always #5 clk = ~clk;

  id_ex_hazard_reg #(.DATA_WIDTH(64), .REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_set_flags(id_set_flags), .id_uses_rm(id_uses_rm),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .flush(flush),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_set_flags(ex_set_flags), .ex_alu_op(ex_alu_op),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .stall_count(stall_count)
  );

  id_ex_hazard_reg #(.DATA_WIDTH(64), .REG_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_set_flags(id_set_flags), .id_uses_rm(id_uses_rm),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .flush(flush),
    .stall_o(s_stall), .ex_valid(s_valid), .ex_reg_write(s_rw),
    .ex_mem_read(s_mr), .ex_mem_write(s_mw), .ex_mem_to_reg(s_m2r),
    .ex_alu_src(s_as), .ex_set_flags(s_sf), .ex_alu_op(s_op),
    .ex_rn(s_rn), .ex_rm(s_rm), .ex_rd(s_rd),
    .ex_rdata1(s_d1), .ex_rdata2(s_d2), .ex_imm(s_imm),
    .stall_count(s_count)
  );

  // ---------------- reference model: contents of the EX slot ----------------
  typedef struct packed {
    logic        valid, rw, mr, mw, m2r, as, sf;
    logic [2:0]  op;
    logic [4:0]  rn, rm, rd;
    logic [63:0] d1, d2, imm;
  } slot_t;

  slot_t m_ex;
  int    m_hazards;   // total load-use bubbles since reset (unbounded)
  int    checks = 0;
  int    errors = 0;

  function automatic slot_t bubble();
    slot_t b;
    b = '0;
    b.rn = 5'd31; b.rm = 5'd31; b.rd = 5'd31;
    return b;
  endfunction

  // Does the instruction in ID read the register a load in EX is fetching?
  function automatic bit model_hazard();
    bit reads;
    reads = (id_rn == m_ex.rd) || (id_uses_rm && id_rm == m_ex.rd);
    return id_valid && m_ex.valid && m_ex.mr && (m_ex.rd != 5'd31) && reads;
  endfunction

  task automatic model_reset();
    m_ex = bubble();
    m_hazards = 0;
  endtask

  task automatic model_clock();
    slot_t n;
    if (flush) begin
      n = bubble();
    end else if (model_hazard()) begin
      n = bubble();
      m_hazards++;
    end else begin
      n.valid = id_valid;
      n.rw  = id_valid ? id_reg_write  : 1'b0;
      n.mr  = id_valid ? id_mem_read   : 1'b0;
      n.mw  = id_valid ? id_mem_write  : 1'b0;
      n.m2r = id_valid ? id_mem_to_reg : 1'b0;
      n.as  = id_valid ? id_alu_src    : 1'b0;
      n.sf  = id_valid ? id_set_flags  : 1'b0;
      n.op  = id_valid ? id_alu_op     : 3'd0;
      n.rn = id_rn; n.rm = id_rm; n.rd = id_rd;
      n.d1 = id_rdata1; n.d2 = id_rdata2; n.imm = id_imm;
    end
    m_ex = n;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input bit force_data);
    int sat;
    sat = (m_hazards > 3) ? 3 : m_hazards;
    chk("ex_valid", 64'(ex_valid), 64'(m_ex.valid));
    chk("ex_ctrl", 64'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                        ex_alu_src, ex_set_flags, ex_alu_op}),
        64'({m_ex.rw, m_ex.mr, m_ex.mw, m_ex.m2r, m_ex.as, m_ex.sf, m_ex.op}));
    chk("ex_spec", 64'({ex_rn, ex_rm, ex_rd}), 64'({m_ex.rn, m_ex.rm, m_ex.rd}));
    if (m_ex.valid || force_data) begin
      chk("ex_rdata1", ex_rdata1, m_ex.d1);
      chk("ex_rdata2", ex_rdata2, m_ex.d2);
      chk("ex_imm", ex_imm, m_ex.imm);
    end
    chk("stall_count", 64'(stall_count), 64'((m_hazards > 65535) ? 65535 : m_hazards));
    chk("stall_count_sat", 64'(s_count), 64'(sat));
    chk("sat_inst_valid", 64'(s_valid), 64'(m_ex.valid));
  endtask

  // One clock: stall_o checked mid-cycle, registers checked just after the edge.
  task automatic tick();
    bit exp_stall;
    @(negedge clk);
    exp_stall = model_hazard() && !flush;
    chk("stall_o", 64'(stall_o), 64'(exp_stall));
    chk("stall_o_sat", 64'(s_stall), 64'(exp_stall));
    @(posedge clk);
    model_clock();
    #1;
    chk_outputs(1'b0);
  endtask

  task automatic set_id(input bit v, input bit rw, input bit mr, input bit mw,
                        input bit m2r, input bit as, input logic [2:0] op,
                        input bit sf, input bit urm, input logic [4:0] rn,
                        input logic [4:0] rm, input logic [4:0] rd,
                        input logic [63:0] d1, input logic [63:0] d2,
                        input logic [63:0] imm, input bit fl);
    id_valid = v; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_mem_to_reg = m2r; id_alu_src = as; id_alu_op = op; id_set_flags = sf;
    id_uses_rm = urm; id_rn = rn; id_rm = rm; id_rd = rd;
    id_rdata1 = d1; id_rdata2 = d2; id_imm = imm; flush = fl;
  endtask

  // LDUR Xrd, [Xrn, #imm]
  task automatic ldur(input logic [4:0] rd, input logic [4:0] rn);
    set_id(1, 1, 1, 0, 1, 1, 3'd2, 0, 0, rn, 5'd0, rd, 64'h100, 64'h0, 64'h8, 0);
  endtask

  // ADD Xrd, Xrn, Xrm
  task automatic add(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                     input bit fl);
    set_id(1, 1, 0, 0, 0, 0, 3'd2, 0, 1, rn, rm, rd, 64'h10, 64'h20, 64'h0, fl);
  endtask

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(4, 8));
  endfunction

  initial begin
    // ---------------- power-on reset ----------------
    set_id(0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 0);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall_o", 64'(stall_o), 64'd0);
    chk_outputs(1'b1);
    reset_n = 1'b1;

    // ---------------- pass-through ADD X4, X2, X3 ----------------
    add(5'd4, 5'd2, 5'd3, 0);
    tick();
    chk("pt_ex_rd", 64'(ex_rd), 64'd4);
    chk("pt_ex_rdata1", ex_rdata1, 64'h10);
    chk("pt_ex_reg_write", 64'(ex_reg_write), 64'd1);

    // ---------------- load-use on Rn ----------------
    ldur(5'd5, 5'd1);
    tick();
    add(5'd9, 5'd5, 5'd2, 0);
    tick();                                   // stall + bubble
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    tick();                                   // held ADD captured
    chk("lu_capture_rn", 64'(ex_rn), 64'd5);
    chk("lu_count", 64'(stall_count), 64'd1);

    // ---------------- Rm gating ----------------
    ldur(5'd6, 5'd1);
    tick();
    set_id(1, 1, 0, 0, 0, 1, 3'd2, 0, 0, 5'd1, 5'd6, 5'd10, 64'h1, 64'h2, 64'h3, 0);
    tick();                                   // I-type: rm ignored, no stall
    ldur(5'd6, 5'd1);
    tick();
    add(5'd10, 5'd1, 5'd6, 0);
    tick();                                   // R-type reads rm: stall
    tick();

    // ---------------- flush overrides hazard ----------------
    ldur(5'd7, 5'd1);
    tick();
    add(5'd11, 5'd7, 5'd7, 1);
    tick();
    chk("flush_count", 64'(stall_count), 64'd2);
    flush = 1'b0;

    // ---------------- load to XZR never stalls ----------------
    ldur(5'd31, 5'd1);
    tick();
    add(5'd12, 5'd31, 5'd31, 0);
    tick();

    // ---------------- five hazards: 2-bit counter saturates ----------------
    for (int i = 0; i < 5; i++) begin
      ldur(5'd8, 5'd1);
      tick();
      add(5'd13, 5'd2, 5'd8, 0);
      tick();
      tick();
    end
    chk("sat_hold", 64'(s_count), 64'd3);

    // ---------------- asynchronous reset mid-run ----------------
    ldur(5'd20, 5'd1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_rd", 64'(ex_rd), 64'd31);
    chk("async_rst_stall", 64'(stall_o), 64'd0);
    chk_outputs(1'b1);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // ---------------- random traffic ----------------
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
             3'($urandom_range(0, 7)), $urandom_range(0, 1), $urandom_range(0, 1),
             pick_reg(), pick_reg(), pick_reg(),
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
